// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, flag bit indices and FSM state encoding for
//               the two-port ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned c_DATA_W = 32;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;

    localparam int unsigned c_FLAG_NE = 0;
    localparam int unsigned c_FLAG_EQ = 1;
    localparam int unsigned c_FLAG_LT = 2;
    localparam int unsigned c_FLAG_GT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_dp.sv
`default_nettype none
// ============================================================================
// Module      : alu_dp
// Description : Combinational ALU datapath with unsigned compare flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dp
    import alu_pkg::*;
(
    input  logic [2:0]          i_op,
    input  logic [c_DATA_W-1:0] i_a,
    input  logic [c_DATA_W-1:0] i_b,
    output logic [c_DATA_W-1:0] o_r,
    output logic [3:0]          o_flags
);

    always_comb begin
        o_r = '0;
        // Add/sub wrap modulo 2^32; reserved opcodes leave the result at zero.
        case (i_op)
            c_OP_ADD: o_r = i_a + i_b;
            c_OP_SUB: o_r = i_a - i_b;
            c_OP_AND: o_r = i_a & i_b;
            c_OP_OR:  o_r = i_a | i_b;
            c_OP_XOR: o_r = i_a ^ i_b;
            default:  o_r = '0;
        endcase
    end

    always_comb begin
        o_flags            = '0;
        o_flags[c_FLAG_NE] = (i_a != i_b);
        o_flags[c_FLAG_EQ] = (i_a == i_b);
        o_flags[c_FLAG_LT] = (i_a <  i_b);
        o_flags[c_FLAG_GT] = (i_a >  i_b);
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two requesters share one ALU; round-robin or fixed-priority
//               grant, IDLE/EXEC/RESP handshake FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [2:0]          req0_op,
    input  logic [c_DATA_W-1:0] req0_a,
    input  logic [c_DATA_W-1:0] req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [2:0]          req1_op,
    input  logic [c_DATA_W-1:0] req1_a,
    input  logic [c_DATA_W-1:0] req1_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [c_DATA_W-1:0] rsp_r,
    output logic [3:0]          rsp_flags,
    output logic                busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_grant;
    logic [2:0]          r_op;
    logic [c_DATA_W-1:0] r_a;
    logic [c_DATA_W-1:0] r_b;
    logic                r_id;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [c_DATA_W-1:0] r_rsp_r;
    logic [3:0]          r_rsp_flags;
    logic                w_grant_id;
    logic                w_accept;
    logic [c_DATA_W-1:0] w_alu_r;
    logic [3:0]          w_alu_flags;

    // Port 1 wins only when port 0 is idle, or on contention when port 0 went last.
    always_comb begin
        if (FIXED_PRIO)
            w_grant_id = ~req0_valid;
        else if (req0_valid && req1_valid)
            w_grant_id = ~r_last_grant;
        else
            w_grant_id = ~req0_valid;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((req0_valid || req1_valid) && !rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_r      <= '0;
            r_rsp_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_op         <= w_grant_id ? req1_op : req0_op;
                r_a          <= w_grant_id ? req1_a  : req0_a;
                r_b          <= w_grant_id ? req1_b  : req0_b;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_r     <= w_alu_r;
                r_rsp_flags <= w_alu_flags;
            end else if (r_state == ST_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    alu_dp u_alu_dp (
        .i_op    (r_op),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_r     (w_alu_r),
        .o_flags (w_alu_flags)
    );

    assign req0_ready = w_accept & ~w_grant_id;
    assign req1_ready = w_accept &  w_grant_id;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_r      = r_rsp_r;
    assign rsp_flags  = r_rsp_flags;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
